// File: rtl/ccorr_lags_if.sv
// rtl/ccorr_lags_if.sv - control/sample/result bundle for ccorr_lags; carries out_sat when CCORR_SAT_EN is defined
interface ccorr_lags_if #(
  parameter int DW    = 16,
  parameter int LEN_W = 11,
  parameter int ACC_W = 44,
  parameter int LAG_W = 3
);
  logic                    start;
  logic [LEN_W-1:0]        frame_len;
  logic                    en;
  logic signed [DW-1:0]    x_re;
  logic signed [DW-1:0]    x_im;
  logic signed [DW-1:0]    y_re;
  logic signed [DW-1:0]    y_im;
  logic                    busy;
  logic                    out_valid;
  logic [LAG_W-1:0]        out_lag;
  logic signed [ACC_W-1:0] out_re;
  logic signed [ACC_W-1:0] out_im;
  logic                    done;
  logic [LAG_W-1:0]        peak_lag;
  logic [ACC_W:0]          peak_mag;
`ifdef CCORR_SAT_EN
  logic                    out_sat;
`endif

  modport master (
    output start, frame_len, en, x_re, x_im, y_re, y_im,
    input  busy, out_valid, out_lag, out_re, out_im, done, peak_lag, peak_mag
`ifdef CCORR_SAT_EN
    , input out_sat
`endif
  );

  modport slave (
    input  start, frame_len, en, x_re, x_im, y_re, y_im,
    output busy, out_valid, out_lag, out_re, out_im, done, peak_lag, peak_mag
`ifdef CCORR_SAT_EN
    , output out_sat
`endif
  );
endinterface

// File: rtl/ccorr_lags.sv
// rtl/ccorr_lags.sv - LAGS-lag complex cross-correlator with L1 peak search; CCORR_SAT_EN selects saturating accumulators
module ccorr_lags #(
  parameter int DW    = 16,
  parameter int LAGS  = 8,
  parameter int LEN_W = 11,
  parameter int ACC_W = 44,
  parameter int LAG_W = 3
) (
  input logic         clk,
  input logic         rst,
  ccorr_lags_if.slave bus
);
  localparam int PW = 2 * DW + 1;
  localparam int MW = ACC_W + 1;
`ifdef CCORR_SAT_EN
  localparam int SW = ((ACC_W > PW) ? ACC_W : PW) + 1;
`endif

  typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_DRAIN, S_DUMP, S_DONE} state_t;
  state_t state_q, state_d;

  logic [LEN_W-1:0]        len_q, cnt_q, cnt_inc;
  logic [LAG_W-1:0]        lag_q;
  logic signed [DW-1:0]    ydl_re_q [1:LAGS-1];
  logic signed [DW-1:0]    ydl_im_q [1:LAGS-1];
  logic signed [DW-1:0]    tap_re [LAGS];
  logic signed [DW-1:0]    tap_im [LAGS];
  logic signed [PW-1:0]    prod_re_d [LAGS];
  logic signed [PW-1:0]    prod_im_d [LAGS];
  logic signed [PW-1:0]    prod_re_q [LAGS];
  logic signed [PW-1:0]    prod_im_q [LAGS];
  logic                    prod_vld_q;
  logic signed [ACC_W-1:0] acc_re_q [LAGS];
  logic signed [ACC_W-1:0] acc_im_q [LAGS];
  logic signed [ACC_W-1:0] acc_re_d [LAGS];
  logic signed [ACC_W-1:0] acc_im_d [LAGS];
  logic signed [MW-1:0]    cur_re, cur_im;
  logic [MW-1:0]           cur_mag;
  logic                    accept, start_go;

  logic                    out_valid_q, done_q;
  logic [LAG_W-1:0]        out_lag_q, peak_lag_q;
  logic signed [ACC_W-1:0] out_re_q, out_im_q;
  logic [MW-1:0]           peak_mag_q;

`ifdef CCORR_SAT_EN
  logic [LAGS-1:0]         sat_q, sat_d;
  logic                    ovf_re [LAGS];
  logic                    ovf_im [LAGS];
  logic                    out_sat_q;

  // Add at a width that cannot overflow, then clamp to the ACC_W range.
  function automatic logic signed [ACC_W-1:0] sat_add(
    input  logic signed [ACC_W-1:0] a,
    input  logic signed [PW-1:0]    p,
    output logic                    ovf
  );
    logic signed [SW-1:0] s;
    s   = SW'(a) + SW'(p);
    ovf = (s[SW-1:ACC_W-1] != {(SW-ACC_W+1){s[SW-1]}});
    if (!ovf) return s[ACC_W-1:0];
    return s[SW-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  endfunction
`endif

  assign accept   = (state_q == S_ACCUM) && bus.en;
  assign start_go = (state_q == S_IDLE) && bus.start;
  assign cnt_inc  = cnt_q + LEN_W'(1);

  // Taps: lag 0 is the live y sample, lag k is y delayed by k accepted samples; form x*conj(y_k).
  always_comb begin
    tap_re[0] = bus.y_re;
    tap_im[0] = bus.y_im;
    for (int k = 1; k < LAGS; k++) begin
      tap_re[k] = ydl_re_q[k];
      tap_im[k] = ydl_im_q[k];
    end
    for (int k = 0; k < LAGS; k++) begin
      prod_re_d[k] = PW'(bus.x_re) * PW'(tap_re[k]) + PW'(bus.x_im) * PW'(tap_im[k]);
      prod_im_d[k] = PW'(bus.x_im) * PW'(tap_re[k]) - PW'(bus.x_re) * PW'(tap_im[k]);
    end
  end

  // Next accumulator values from the registered products (wrap or saturate).
  always_comb begin
`ifdef CCORR_SAT_EN
    sat_d = sat_q;
`endif
    for (int k = 0; k < LAGS; k++) begin
`ifdef CCORR_SAT_EN
      acc_re_d[k] = sat_add(acc_re_q[k], prod_re_q[k], ovf_re[k]);
      acc_im_d[k] = sat_add(acc_im_q[k], prod_im_q[k], ovf_im[k]);
      sat_d[k]    = sat_q[k] | ovf_re[k] | ovf_im[k];
`else
      acc_re_d[k] = acc_re_q[k] + ACC_W'(prod_re_q[k]);
      acc_im_d[k] = acc_im_q[k] + ACC_W'(prod_im_q[k]);
`endif
    end
  end

  // L1 magnitude of the lag being dumped, one bit wider so |most-negative| is exact.
  always_comb begin
    cur_re  = MW'(acc_re_q[lag_q]);
    cur_im  = MW'(acc_im_q[lag_q]);
    cur_mag = (cur_re[MW-1] ? MW'(-cur_re) : MW'(cur_re))
            + (cur_im[MW-1] ? MW'(-cur_im) : MW'(cur_im));
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state; an empty frame skips straight to the drain cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.start) state_d = (bus.frame_len == '0) ? S_DRAIN : S_ACCUM;
      S_ACCUM: if (bus.en && (cnt_inc == len_q)) state_d = S_DRAIN;
      S_DRAIN: state_d = S_DUMP;
      S_DUMP:  if (lag_q == LAG_W'(LAGS - 1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: delay line, product pipeline, accumulators, result stream and peak tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q       <= '0;
      cnt_q       <= '0;
      lag_q       <= '0;
      prod_vld_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_lag_q   <= '0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      done_q      <= 1'b0;
      peak_lag_q  <= '0;
      peak_mag_q  <= '0;
      for (int k = 1; k < LAGS; k++) begin
        ydl_re_q[k] <= '0;
        ydl_im_q[k] <= '0;
      end
      for (int k = 0; k < LAGS; k++) begin
        prod_re_q[k] <= '0;
        prod_im_q[k] <= '0;
        acc_re_q[k]  <= '0;
        acc_im_q[k]  <= '0;
      end
`ifdef CCORR_SAT_EN
      sat_q     <= '0;
      out_sat_q <= 1'b0;
`endif
    end else begin
      prod_vld_q <= accept;
      if (accept) begin
        cnt_q       <= cnt_inc;
        ydl_re_q[1] <= bus.y_re;
        ydl_im_q[1] <= bus.y_im;
        for (int k = 2; k < LAGS; k++) begin
          ydl_re_q[k] <= ydl_re_q[k-1];
          ydl_im_q[k] <= ydl_im_q[k-1];
        end
        for (int k = 0; k < LAGS; k++) begin
          prod_re_q[k] <= prod_re_d[k];
          prod_im_q[k] <= prod_im_d[k];
        end
      end
      if (prod_vld_q) begin
        for (int k = 0; k < LAGS; k++) begin
          acc_re_q[k] <= acc_re_d[k];
          acc_im_q[k] <= acc_im_d[k];
        end
`ifdef CCORR_SAT_EN
        sat_q <= sat_d;
`endif
      end

      lag_q       <= (state_q == S_DUMP) ? lag_q + LAG_W'(1) : '0;
      out_valid_q <= (state_q == S_DUMP);
      out_lag_q   <= (state_q == S_DUMP) ? lag_q : '0;
      out_re_q    <= (state_q == S_DUMP) ? acc_re_q[lag_q] : '0;
      out_im_q    <= (state_q == S_DUMP) ? acc_im_q[lag_q] : '0;
      done_q      <= (state_q == S_DONE);
`ifdef CCORR_SAT_EN
      out_sat_q   <= (state_q == S_DUMP) ? sat_q[lag_q] : 1'b0;
`endif
      // Strictly-greater update keeps the lowest lag on ties.
      if ((state_q == S_DUMP) && (cur_mag > peak_mag_q)) begin
        peak_mag_q <= cur_mag;
        peak_lag_q <= lag_q;
      end

      if (start_go) begin
        len_q      <= bus.frame_len;
        cnt_q      <= '0;
        prod_vld_q <= 1'b0;
        peak_lag_q <= '0;
        peak_mag_q <= '0;
        for (int k = 1; k < LAGS; k++) begin
          ydl_re_q[k] <= '0;
          ydl_im_q[k] <= '0;
        end
        for (int k = 0; k < LAGS; k++) begin
          acc_re_q[k] <= '0;
          acc_im_q[k] <= '0;
        end
`ifdef CCORR_SAT_EN
        sat_q <= '0;
`endif
      end
    end
  end

  assign bus.busy      = (state_q == S_ACCUM) || (state_q == S_DRAIN) || (state_q == S_DUMP);
  assign bus.out_valid = out_valid_q;
  assign bus.out_lag   = out_lag_q;
  assign bus.out_re    = out_re_q;
  assign bus.out_im    = out_im_q;
  assign bus.done      = done_q;
  assign bus.peak_lag  = peak_lag_q;
  assign bus.peak_mag  = peak_mag_q;
`ifdef CCORR_SAT_EN
  assign bus.out_sat   = out_sat_q;
`endif
endmodule

// File: tb/tb_ccorr_lags.sv
// tb/tb_ccorr_lags.sv - self-checking bench for ccorr_lags against a frame-level correlation model
module tb_ccorr_lags;
  localparam int DW = 16, LAGS = 4, LEN_W = 11, ACC_W = 44, LAG_W = 2;
  localparam int ACC_S = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ccorr_lags_if #(.DW(DW), .LEN_W(LEN_W), .ACC_W(ACC_W), .LAG_W(LAG_W)) bus ();
  ccorr_lags_if #(.DW(DW), .LEN_W(LEN_W), .ACC_W(ACC_S), .LAG_W(LAG_W)) sbus ();

  ccorr_lags #(.DW(DW), .LAGS(LAGS), .LEN_W(LEN_W), .ACC_W(ACC_W), .LAG_W(LAG_W))
    dut (.clk(clk), .rst(rst), .bus(bus));
  ccorr_lags #(.DW(DW), .LAGS(LAGS), .LEN_W(LEN_W), .ACC_W(ACC_S), .LAG_W(LAG_W))
    dut_s (.clk(clk), .rst(rst), .bus(sbus));

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_cyc = 0;

  longint mx_re[$], mx_im[$], my_re[$], my_im[$];
  longint exp_re[$], exp_im[$], exp_pm[$];
  int     exp_lag[$], exp_pl[$], exp_last[$];
  longint got_re [LAGS];
  longint got_im [LAGS];
  longint got_pl, got_pm;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, longint got, longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endfunction

  function automatic longint wrap_acc(longint v);
    return (v <<< (64 - ACC_W)) >>> (64 - ACC_W);
  endfunction

  function automatic longint labs(longint v);
    return (v < 0) ? -v : v;
  endfunction

  // Frame model: direct correlation sum over the accepted samples, then L1 peak search.
  task automatic model_finish(input int lc);
    int n;
    longint r_re, r_im, m, bestm;
    int bl;
    n = mx_re.size();
    bestm = 0;
    bl = 0;
    for (int k = 0; k < LAGS; k++) begin
      r_re = 0;
      r_im = 0;
      for (int i = k; i < n; i++) begin
        r_re += mx_re[i] * my_re[i-k] + mx_im[i] * my_im[i-k];
        r_im += mx_im[i] * my_re[i-k] - mx_re[i] * my_im[i-k];
      end
      r_re = wrap_acc(r_re);
      r_im = wrap_acc(r_im);
      exp_re.push_back(r_re);
      exp_im.push_back(r_im);
      exp_lag.push_back(k);
      m = labs(r_re) + labs(r_im);
      if (m > bestm) begin
        bestm = m;
        bl = k;
      end
    end
    exp_pl.push_back(bl);
    exp_pm.push_back(bestm);
    exp_last.push_back(lc);
  endtask

  // Compare process: every result beat and every done pulse is checked against the model.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid) begin
        chk("valid_has_result", longint'(exp_lag.size() != 0), 1);
        if (exp_lag.size() != 0) begin
          if (exp_lag[0] == 0) chk("first_valid_latency", cyc - exp_last[0], 3);
          chk("out_lag", bus.out_lag, exp_lag[0]);
          chk("out_re", bus.out_re, exp_re[0]);
          chk("out_im", bus.out_im, exp_im[0]);
          got_re[bus.out_lag] = bus.out_re;
          got_im[bus.out_lag] = bus.out_im;
          void'(exp_lag.pop_front());
          void'(exp_re.pop_front());
          void'(exp_im.pop_front());
        end
      end
      if (bus.done) begin
        chk("done_has_frame", longint'(exp_pl.size() != 0), 1);
        if (exp_pl.size() != 0) begin
          chk("done_latency", cyc - exp_last[0], LAGS + 3);
          chk("results_all_out", exp_lag.size(), 0);
          chk("peak_lag", bus.peak_lag, exp_pl[0]);
          chk("peak_mag", longint'(bus.peak_mag), exp_pm[0]);
          got_pl = bus.peak_lag;
          got_pm = longint'(bus.peak_mag);
          void'(exp_pl.pop_front());
          void'(exp_pm.pop_front());
          void'(exp_last.pop_front());
        end
        done_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int len);
    tick();
    bus.start = 1'b1;
    bus.frame_len = LEN_W'(len);
    bus.en = 1'b0;
    last_cyc = cyc;
    mx_re.delete(); mx_im.delete(); my_re.delete(); my_im.delete();
  endtask

  task automatic send(input int xr, input int xi, input int yr, input int yi);
    tick();
    bus.start = 1'b0;
    bus.en = 1'b1;
    bus.x_re = DW'(xr); bus.x_im = DW'(xi);
    bus.y_re = DW'(yr); bus.y_im = DW'(yi);
    mx_re.push_back(xr); mx_im.push_back(xi);
    my_re.push_back(yr); my_im.push_back(yi);
    last_cyc = cyc;
    @(negedge clk);
    chk("busy_in_frame", bus.busy, 1);
  endtask

  task automatic stall();
    tick();
    bus.start = 1'b0;
    bus.en = 1'b0;
    bus.x_re = DW'($urandom); bus.x_im = DW'($urandom);
    bus.y_re = DW'($urandom); bus.y_im = DW'($urandom);
    @(negedge clk);
    chk("busy_in_stall", bus.busy, 1);
  endtask

  task automatic end_frame();
    tick();
    bus.start = 1'b0;
    bus.en = 1'b0;
    model_finish(last_cyc);
  endtask

  task automatic wait_done();
    int d0;
    bit ok;
    d0 = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      tick();
      if (done_cnt != d0) ok = 1'b1;
    end
    chk("done_seen", ok, 1);
  endtask

  task automatic const_frame(input bit stalls);
    start_frame(8);
    for (int i = 0; i < 8; i++) begin
      send(100, 0, 100, 0);
      if (stalls && i < 7) stall();
    end
    end_frame();
  endtask

  task automatic pin_const();
    chk("const_re0", got_re[0], 80000);
    chk("const_re1", got_re[1], 70000);
    chk("const_re2", got_re[2], 60000);
    chk("const_re3", got_re[3], 50000);
    chk("const_im0", got_im[0], 0);
    chk("const_peak_lag", got_pl, 0);
    chk("const_peak_mag", got_pm, 80000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    longint s_re0, s_re3;
    int d0;
`ifdef CCORR_SAT_EN
    int s_sat0, s_sat3;
    s_sat0 = 0;
    s_sat3 = 0;
`endif
    bus.start = 1'b0; bus.frame_len = '0; bus.en = 1'b0;
    bus.x_re = '0; bus.x_im = '0; bus.y_re = '0; bus.y_im = '0;
    sbus.start = 1'b0; sbus.frame_len = '0; sbus.en = 1'b0;
    sbus.x_re = '0; sbus.x_im = '0; sbus.y_re = '0; sbus.y_im = '0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_out_re", bus.out_re, 0);
    chk("rst_peak_lag", bus.peak_lag, 0);
    chk("rst_peak_mag", longint'(bus.peak_mag), 0);

    // Constant input.
    const_frame(1'b0);
    wait_done();
    pin_const();

    // Impulse delay: x at n=3, y at n=1 -> only lag 2.
    start_frame(6);
    for (int i = 0; i < 6; i++)
      send((i == 3) ? 1000 : 0, 0, 0, (i == 1) ? 1000 : 0);
    end_frame();
    wait_done();
    chk("imp_re2", got_re[2], 0);
    chk("imp_im2", got_im[2], -1000000);
    chk("imp_im0", got_im[0], 0);
    chk("imp_peak_lag", got_pl, 2);
    chk("imp_peak_mag", got_pm, 1000000);

    // Stalled constant input.
    const_frame(1'b1);
    wait_done();
    pin_const();

    // Reset mid-frame, then a clean frame.
    start_frame(8);
    for (int i = 0; i < 5; i++) send(100, 0, 100, 0);
    tick();
    bus.en = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.en = 1'b0;
    d0 = done_cnt;
    repeat (12) tick();
    chk("abort_no_done", done_cnt, d0);
    @(negedge clk);
    chk("abort_idle", bus.busy, 0);
    const_frame(1'b0);
    wait_done();
    pin_const();

    // Empty frame.
    start_frame(0);
    end_frame();
    wait_done();
    chk("empty_re0", got_re[0], 0);
    chk("empty_peak_lag", got_pl, 0);
    chk("empty_peak_mag", got_pm, 0);

    // Start pulsed during DUMP must not restart the block.
    const_frame(1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    chk("dump_seen", seen, 1);
    tick();
    bus.start = 1'b1;
    bus.frame_len = LEN_W'(3);
    tick();
    bus.start = 1'b0;
    wait_done();
    repeat (3) tick();
    @(negedge clk);
    chk("no_restart_busy", bus.busy, 0);
    pin_const();

    // Narrow accumulator: saturation or wrap at ACC_W=32.
    tick();
    sbus.start = 1'b1;
    sbus.frame_len = LEN_W'(4);
    tick();
    sbus.start = 1'b0;
    sbus.en = 1'b1;
    sbus.x_re = -16'sd32768;
    sbus.y_re = -16'sd32768;
    repeat (3) tick();
    tick();
    sbus.en = 1'b0;
    s_re0 = 1;
    s_re3 = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sbus.out_valid && sbus.out_lag == 2'd0) begin
        s_re0 = sbus.out_re;
`ifdef CCORR_SAT_EN
        s_sat0 = sbus.out_sat;
`endif
      end
      if (sbus.out_valid && sbus.out_lag == 2'd3) begin
        s_re3 = sbus.out_re;
`ifdef CCORR_SAT_EN
        s_sat3 = sbus.out_sat;
`endif
      end
    end
    chk("narrow_lag3_re", s_re3, 1073741824);
`ifdef CCORR_SAT_EN
    chk("sat_lag0_re", s_re0, 2147483647);
    chk("sat_lag0_flag", s_sat0, 1);
    chk("sat_lag3_flag", s_sat3, 0);
`else
    chk("wrap_lag0_re", s_re0, 0);
`endif

    repeat (4) tick();
    chk("model_drained", exp_lag.size() + exp_pl.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ccorr_lags.md
Name: ccorr_lags

Overview:
- Parametrised successor to the 4-lag CCorr correlator.
- Computes the complex cross-correlation R[k] = sum over n of x[n]*conj(y[n-k]), for k = 0..LAGS-1, over a runtime-programmable frame of accepted samples.
- Conjugation of y is done internally; the upstream stimulus no longer negates y_im.
- After each frame, streams the LAGS results out one per cycle and reports the peak lag by L1 magnitude.

Parameters:
- DW, 16: signed input width per real/imag component.
- LAGS, 8: number of correlation lags (>=2).
- LEN_W, 11: width of frame_len; max frame = 2^LEN_W - 1 samples.
- ACC_W, 44: accumulator/output width. Default is 2*DW+1+LEN_W.
- LAG_W, 3: width of lag index. Must satisfy 2^LAG_W >= LAGS.

Ports:
- clk in 1: single clock, all logic rising-edge.
- rst in 1: synchronous, active-high reset.
- start in 1: one-cycle pulse; begins a frame, latches frame_len.
- frame_len in LEN_W: number of accepted samples per frame.
- en in 1: sample-valid; x/y are accepted when en=1 in ACCUM.
- x_re, x_im in DW each: signed x sample.
- y_re, y_im in DW each: signed y sample (not pre-conjugated).
- busy out 1: high in ACCUM, DRAIN, DUMP.
- out_valid out 1: one result per cycle during DUMP.
- out_lag out LAG_W: lag index of the current result.
- out_re, out_im out ACC_W each: signed R[out_lag].
- done out 1: one-cycle pulse after the last result.
- peak_lag out LAG_W: lag of maximum |re|+|im|; valid from done until next start.
- peak_mag out ACC_W+1: unsigned magnitude at peak_lag.

Behaviour:
- Reset: all outputs 0; state IDLE; accumulators, y delay line, sample counter and peak registers cleared.
- States: IDLE -> ACCUM -> DRAIN -> DUMP -> DONE -> IDLE.
- IDLE
  - start=1: latch frame_len, clear accumulators, delay line and peak, go to ACCUM.
  - en is ignored.
  - If the latched frame_len = 0, go directly to DRAIN; all results are 0.
- ACCUM
  - Each cycle with en=1: y shifts into a LAGS-deep delay line, tap 0 = current y.
  - Per lag k: product re = xr*yr_k + xi*yi_k; product im = xi*yr_k - xr*yi_k. Products are 2*DW+1 bits signed, registered one stage, then added to the k accumulator.
  - The delay line starts zero-filled, so early samples contribute 0 for lags greater than n.
  - en=0 cycles are stalls with no accumulation.
  - The counter counts accepted samples. When the count reaches frame_len, go to DRAIN.
- DRAIN: 1 cycle so the registered products land; then DUMP.
- DUMP
  - LAGS consecutive cycles: out_valid=1, out_lag = 0..LAGS-1 ascending, out_re/out_im = accumulator values.
  - Peak update: mag = |re|+|im| computed at ACC_W+1 bits, so |most-negative| is exact. The stored peak is replaced only if mag > stored; ties keep the lowest lag.
- DONE: done=1 for one cycle, peak_lag/peak_mag valid; next cycle IDLE.
- Latency: first out_valid occurs 3 cycles after the cycle accepting the last sample. done occurs LAGS+3 cycles after it.
- start while busy: ignored.
- en and start together in IDLE: that en sample is not accepted.
- rst in any state: returns to IDLE in the same edge; the partial frame is discarded; no done pulse.
- Arithmetic without the optional feature is two's-complement wrap at ACC_W.

Optional Feature:
- Macro: CCORR_SAT_EN.
- Defined: each accumulator add saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Each lag has a sticky sat flag, cleared on start; the flag ORs into a 1-bit out_sat port, valid with out_valid.
- Undefined: accumulators wrap; out_sat port absent.

Test Plan:
- Bench DW=16, LAGS=4, LAG_W=2.
- Constant input: x=y=(100,0), frame_len=8, en=1 continuous.
  - Expected: out_re = 80000, 70000, 60000, 50000 for lags 0..3; out_im = 0.
  - Peak: peak_lag=0, peak_mag=80000; done exactly 7 cycles after the last sample.
- Impulse delay: x=(1000,0) only at n=3, y=(0,1000) only at n=1, zeros elsewhere, frame_len=6.
  - Expected: lag2 re=0, im=-1000000; all others 0.
  - Peak: peak_lag=2, peak_mag=1000000.
- Stalls: repeat the constant-input case with en toggling 1,0,1,0.
  - Expected: identical results; busy held high throughout; no extra out_valid cycles.
- Reset mid-frame: rst high at accepted sample 5 of the constant-input frame, then start a fresh frame.
  - Expected: no done from the aborted frame; fresh results equal the constant-input values exactly.
- Edge cases.
  - frame_len=0: 4 zero results, peak_lag=0, peak_mag=0.
  - start pulsed during DUMP: ignored, no restart.
- Saturation/wrap: ACC_W=32, x=y=(-32768,0), frame_len=4.
  - With CCORR_SAT_EN: lag0 out_re = 2147483647, out_sat=1.
  - Without it: lag0 out_re = 0 (wrap).
